run_detector: RTL

RUN_DETECTOR -- requirements
Module: run_detector

---
 rtl/run_detector_pkg.sv | 38 +++
 rtl/run_detector_if.sv | 52 +++++
 rtl/run_detector_sat_counter.sv | 34 +++
 rtl/run_detector.sv | 122 ++++++++++++
 4 files changed

// File: rtl/run_detector_pkg.sv
// -----------------------------------------------------------------------------
// run_det_pkg
// Shared types and constants for the run detector slice.
//   state_e       : detector FSM state (IDLE, RUN, HIT)
//   MODE_*        : 2-bit polarity filter codes applied to the hit outputs
//   mode_permits(): whether a run of polarity pol may raise y / hit_pulse
//                   under a given mode
// -----------------------------------------------------------------------------
package run_det_pkg;

  // IDLE : no valid sample seen since reset
  // RUN  : run in progress, shorter than RUN_LEN
  // HIT  : run has reached RUN_LEN (and stays here while it continues)
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HIT  = 2'b10
  } state_e;

  localparam logic [1:0] MODE_BOTH = 2'b00;  // report runs of either polarity
  localparam logic [1:0] MODE_ZERO = 2'b01;  // report runs of zeros only
  localparam logic [1:0] MODE_ONE  = 2'b10;  // report runs of ones only
  localparam logic [1:0] MODE_OFF  = 2'b11;  // never report

  function automatic logic mode_permits(input logic [1:0] mode, input logic pol);
    logic ok;
    ok = 1'b0;
    case (mode)
      MODE_BOTH: ok = 1'b1;
      MODE_ZERO: ok = ~pol;
      MODE_ONE:  ok = pol;
      MODE_OFF:  ok = 1'b0;
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/run_detector_if.sv
// -----------------------------------------------------------------------------
// run_detector_if
// Sample / result bundle of the run detector.
//   in_valid, in_bit : serial sample and its qualifier   (master -> slave)
//   mode             : polarity filter, see run_det_pkg   (master -> slave)
//   y, y_val         : hit flag and polarity of the run   (slave -> master)
//   run_len          : current run length, saturating     (slave -> master)
//   hit_pulse        : one-cycle pulse per new hit        (slave -> master)
//   ev_cnt           : hit event counter, only when RUN_DET_EVCNT_EN is defined
// Parameters CW / EVW must match the run_detector instance using it.
// -----------------------------------------------------------------------------
interface run_detector_if #(
  parameter int CW  = 8,
  parameter int EVW = 16
);

  logic          in_valid;
  logic          in_bit;
  logic [1:0]    mode;
  logic          y;
  logic          y_val;
  logic [CW-1:0] run_len;
  logic          hit_pulse;
`ifdef RUN_DET_EVCNT_EN
  logic [EVW-1:0] ev_cnt;
`endif

  if (EVW < 1) begin : g_bad_evw
    $error("run_detector_if: EVW must be at least 1");
  end

`ifdef RUN_DET_EVCNT_EN
  modport master (
    output in_valid, in_bit, mode,
    input  y, y_val, run_len, hit_pulse, ev_cnt
  );
  modport slave (
    input  in_valid, in_bit, mode,
    output y, y_val, run_len, hit_pulse, ev_cnt
  );
`else
  modport master (
    output in_valid, in_bit, mode,
    input  y, y_val, run_len, hit_pulse
  );
  modport slave (
    input  in_valid, in_bit, mode,
    output y, y_val, run_len, hit_pulse
  );
`endif

endinterface

// File: rtl/run_detector_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Width-parametrised up-counter that saturates at all-ones.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset, clears count to 0
//   load1 : restart the count at 1 (wins over inc)
//   inc   : add one unless already saturated
//   count : current value
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load1,
  input  logic         inc,
  output logic [W-1:0] count
);

  // NOTE: reset is sampled on the clock edge like any other input, so it
  // belongs inside the clocked branch rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with <= so every register in the design sees
    // the pre-edge values of the others, independent of block ordering.
    if (rst) begin
      count <= '0;
    end else if (load1) begin
      count <= W'(1);
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/run_detector.sv
// -----------------------------------------------------------------------------
// run_detector
// Detects runs of RUN_LEN or more consecutive equal valid samples on a serial
// stream and reports them subject to a polarity filter.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : run_detector_if.slave
//          in_valid/in_bit/mode in; y, y_val, run_len, hit_pulse
//          (and ev_cnt) out
// Parameters:
//   RUN_LEN : equal samples needed for a hit, 2 .. 2**CW-1
//   CW      : run-length counter width
//   EVW     : event counter width
// Optional feature: define RUN_DET_EVCNT_EN to add the wrapping hit event
// counter ev_cnt; without it the port and register do not exist.
// -----------------------------------------------------------------------------
module run_detector
  import run_det_pkg::*;
#(
  parameter int RUN_LEN = 3,
  parameter int CW      = 8,
  parameter int EVW     = 16
) (
  input  logic           clk,
  input  logic           rst,
  run_detector_if.slave  bus
);

  if (RUN_LEN < 2 || RUN_LEN > (2 ** CW) - 1) begin : g_bad_run_len
    $error("run_detector: RUN_LEN must lie in 2 .. 2**CW-1");
  end
  if (EVW < 1) begin : g_bad_evw
    $error("run_detector: EVW must be at least 1");
  end

  // Count value one short of a hit: an equal sample arriving while RUN holds
  // this value is the one that completes the run.
  localparam logic [CW-1:0] RUN_LEN_M1 = CW'(RUN_LEN - 1);

  state_e        state;
  logic          y_val_q;
  logic          pulse_q;
  logic [CW-1:0] run_len_q;

  logic load1;
  logic inc;
  logic enter_hit;
  logic pulse_next;

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    load1     = 1'b0;
    inc       = 1'b0;
    enter_hit = 1'b0;
    if (bus.in_valid) begin
      if (state == IDLE || bus.in_bit != y_val_q) begin
        load1 = 1'b1;
      end else begin
        inc       = 1'b1;
        enter_hit = (state == RUN) && (run_len_q == RUN_LEN_M1);
      end
    end
  end

  // The pulse is qualified by the mode in force on the edge that completes
  // the run; the new run has the polarity of the sample being taken.
  assign pulse_next = enter_hit && mode_permits(bus.mode, bus.in_bit);

  sat_counter #(
    .W (CW)
  ) u_run_len (
    .clk   (clk),
    .rst   (rst),
    .load1 (load1),
    .inc   (inc),
    .count (run_len_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      y_val_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= pulse_next;
      if (load1) begin
        // First sample after reset, or a polarity change: a fresh run of 1,
        // which is always below RUN_LEN.
        state   <= RUN;
        y_val_q <= bus.in_bit;
      end else if (enter_hit) begin
        state <= HIT;
      end
      // An equal sample in HIT keeps HIT; the counter handles saturation.
    end
  end

`ifdef RUN_DET_EVCNT_EN
  logic [EVW-1:0] ev_cnt_q;

  // Counts on the same edge that raises hit_pulse, so ev_cnt already
  // includes the pulse currently visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      ev_cnt_q <= '0;
    end else if (pulse_next) begin
      ev_cnt_q <= ev_cnt_q + EVW'(1);
    end
  end

  assign bus.ev_cnt = ev_cnt_q;
`endif

  // y is a function of registered state and the live mode, so a mode change
  // is reflected without disturbing the run.
  assign bus.y         = (state == HIT) && mode_permits(bus.mode, y_val_q);
  assign bus.y_val     = y_val_q;
  assign bus.run_len   = run_len_q;
  assign bus.hit_pulse = pulse_q;

endmodule
